fetch_queue: RTL
================

# fetch_queue

Instruction-fetch front end that sits directly downstream of the program counter and upstream of decode. It owns the fetch PC and issues in-order requests to instruction memory over a req/gnt handshake. It buffers returned instructions with their PCs in a small queue and presents them to decode through a valid/ready handshake. Branch, jump and exception redirects flush the queue and discard stale in-flight responses.

## Interface
- `DEPTH`, 4: instruction queue entries (power of two, ≥2).
- `MAX_OUT`, 2: maximum outstanding imem requests (1..DEPTH).
- `RESET_PC`, 32'h0000_3000: fetch PC after reset.
- `Clk` in 1: single clock, all state on rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `redirect_valid` in 1: load a new fetch PC and flush (branch/jump/eret/exception).
- `redirect_pc` in 32: target PC, word-aligned.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: request address, equal to the current fetch PC.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid; responses are in order, ≥1 cycle after gnt.
- `imem_rdata` in 32: instruction word.
- `inst_valid` out 1: queue head valid.
- `inst_data` out 32: head instruction.
- `inst_pc` out 32: head PC.
- `inst_ready` in 1: decode consumes the head this cycle.

## Operation
- State: `fetch_pc`, `outstanding` (0..MAX_OUT), `drop_cnt` (0..MAX_OUT), a PC FIFO of issued addresses (MAX_OUT deep), and an instruction queue of {pc,inst} (DEPTH deep).
- Issue: `imem_req` = !redirect_valid && outstanding < MAX_OUT && (count + outstanding − drop_cnt) < DEPTH. Slots are reserved at issue, so the queue never overflows.
- `imem_addr` = `fetch_pc`. Address is held stable while `imem_req` is high without gnt.
- Accepted request (req && gnt): push `fetch_pc` to the PC FIFO, `fetch_pc += 4` (wraps at 2^32), `outstanding++`.
- Response (rvalid): pop the PC FIFO and `outstanding--`. If `drop_cnt` > 0, discard the response and `drop_cnt--`. Otherwise enqueue {popped pc, rdata}.
- Dequeue: inst_valid && inst_ready pops the head.
- Simultaneous enqueue and dequeue are legal at any occupancy, including full and empty. Empty queue: no bypass; the response appears the next cycle.
- Redirect has priority over all other events in that cycle:
  - `fetch_pc` ← redirect_pc.
  - Instruction queue emptied.
  - `drop_cnt` ← outstanding after this cycle's gnt/rvalid updates.
  - `imem_req` forced low, so no gnt is accepted.
  - An `inst_ready` in the redirect cycle is ignored.
- `rvalid` while `outstanding` = 0 is a protocol error. It is ignored and an assertion flags it.

## Timing
- Reset values:
  - `fetch_pc` = RESET_PC; `imem_addr` = RESET_PC.
  - `imem_req` = 0 while Reset is low.
  - `inst_valid` = 0; `inst_data` = 0; `inst_pc` = 0.
  - All counters 0.
- First `imem_req` is high in the first cycle after Reset deasserts.
- Latency: gnt in cycle N, rvalid in cycle N+k (k≥1), `inst_valid` high in cycle N+k+1.
- Sustained throughput of 1 instruction/cycle when k ≤ MAX_OUT−1 and decode is always ready.
- Redirect asserted in cycle R:
  - `inst_valid` = 0 in R+1.
  - `imem_req` with `imem_addr` = redirect_pc in R+1, unless outstanding = MAX_OUT.
- Reset mid-operation clears all state immediately. Responses arriving after reset are not expected; the environment also resets imem.

## Structure
- Shared package `cpu_pkg`: `RESET_PC` (32'h0000_3000), `EXC_VECTOR` (32'h0000_4180), and a fetch-entry typedef {pc[31:0], inst[31:0]}.
- Sub-module `sync_fifo`: parameterised width/depth, push, pop, count, full, empty, flush. Instantiated twice: PC FIFO (32b × MAX_OUT) and instruction queue (64b × DEPTH).
- The top level holds fetch_pc, the outstanding/drop counters and the issue logic.

## Test plan
- Reset release, gnt always 1, k=1, ready=1 → addrs 0x3000, 0x3004, 0x3008…; inst_valid from cycle 3; inst_pc tracks each address; one instruction per cycle.
- inst_ready=0 for 10 cycles, k=1 → queue fills to 4 (0x3000–0x300C); imem_req drops with no overflow; releasing ready drains in order.
- gnt low for 3 cycles → imem_req stays high and imem_addr stays 0x3000 throughout.
- Two outstanding (k=3), redirect to 0x4180 the cycle after the second gnt → both late responses dropped; next enqueued inst_pc is 0x4180; inst_valid is 0 in the cycle after the redirect.
- Redirect in the same cycle as rvalid and inst_ready with a full queue → queue empty next cycle; drop_cnt = remaining outstanding; no head pop observed by decode.
- Reset asserted mid-stream with 2 outstanding → all outputs at reset values asynchronously; after release, fetch restarts at 0x3000.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions used by the fetch front end.
//   RESET_PC      : fetch PC after reset
//   EXC_VECTOR    : exception handler entry point
//   fetch_entry_t : {pc, inst} pair held in the instruction queue
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with flush. Head data is presented combinationally
// (first-word fall-through). Push and pop may happen together at any
// occupancy, including full; a pop on an empty FIFO is ignored.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : discard all entries (wins over push/pop)
//   push_i/wdata_i: write an entry
//   pop_i         : remove the head entry
//   rdata_o       : head entry
//   count_o       : number of entries held
//   full_o/empty_o: occupancy flags
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees the slot being written when full, so push is allowed then.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: owns the fetch PC, issues in-order imem
// requests over req/gnt, buffers {pc, inst} responses and hands them to
// decode over valid/ready. A redirect reloads the PC, flushes the queue and
// marks every still-outstanding response for discard.
// Ports:
//   Clk, Reset                  : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc : new fetch PC + flush
//   imem_req, imem_addr         : request valid / address (= fetch PC)
//   imem_gnt                    : request accepted
//   imem_rvalid, imem_rdata     : in-order instruction response
//   inst_valid, inst_data,
//   inst_pc, inst_ready         : decode-side handshake for the queue head
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    import cpu_pkg::*;

    localparam int unsigned OW  = $clog2(MAX_OUT + 1);
    localparam int unsigned QCW = $clog2(DEPTH + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_q, drop_d;

    logic [31:0]  reserved;
    logic         gnt_acc, rsp, rsp_drop, enq, deq;

    logic [31:0]  pcf_head;
    logic [OW-1:0] pcf_count;
    logic         pcf_full, pcf_empty;

    fetch_entry_t iq_wdata, iq_head;
    logic [QCW-1:0] iq_count;
    logic         iq_full, iq_empty;

    logic         unused_flags;
    assign unused_flags = ^{pcf_count, pcf_full, pcf_empty, iq_full};

    // Queue slots already owned by valid entries plus live in-flight requests;
    // responses marked for discard do not hold a slot.
    assign reserved = 32'(iq_count) + 32'(outstanding_q) - 32'(drop_q);

    assign imem_req  = Reset && !redirect_valid &&
                       (outstanding_q < OW'(MAX_OUT)) && (reserved < DEPTH);
    assign imem_addr = fetch_pc_q;

    assign gnt_acc  = imem_req && imem_gnt;
    assign rsp      = imem_rvalid && (outstanding_q != '0);
    assign rsp_drop = rsp && (drop_q != '0);
    assign enq      = rsp && !rsp_drop && !redirect_valid;
    assign deq      = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        outstanding_d = outstanding_q + OW'(gnt_acc) - OW'(rsp);
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q - OW'(rsp_drop);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_d     = outstanding_d;
        end else if (gnt_acc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // Issued addresses, popped by every response (kept or discarded), so the
    // head is always the PC of the response currently on imem_rdata.
    sync_fifo #(
        .WIDTH(32),
        .DEPTH(MAX_OUT)
    ) u_pc_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .flush_i (1'b0),
        .push_i  (gnt_acc),
        .wdata_i (fetch_pc_q),
        .pop_i   (rsp),
        .rdata_o (pcf_head),
        .count_o (pcf_count),
        .full_o  (pcf_full),
        .empty_o (pcf_empty)
    );

    assign iq_wdata = '{pc: pcf_head, inst: imem_rdata};

    sync_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_inst_queue (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .flush_i (redirect_valid),
        .push_i  (enq),
        .wdata_i (iq_wdata),
        .pop_i   (deq),
        .rdata_o (iq_head),
        .count_o (iq_count),
        .full_o  (iq_full),
        .empty_o (iq_empty)
    );

    assign inst_valid = !iq_empty;
    assign inst_data  = iq_empty ? '0 : iq_head.inst;
    assign inst_pc    = iq_empty ? '0 : iq_head.pc;

`ifndef SYNTHESIS
    // A response with nothing in flight is a protocol error; it is ignored.
    rvalid_without_request: assert property (
        @(posedge Clk) disable iff (!Reset) !(imem_rvalid && outstanding_q == '0)
    );
`endif

endmodule
